// File: rtl/byte_striping_pkg.sv
// Shared constants and types for the two-lane byte striping block.
package byte_striping_pkg;

   localparam int          LANES       = 2;
   localparam int          LANE_DATA_W = 32;
   localparam logic [31:0] IDLE_WORD   = 32'hBCBCBCBC;

   typedef logic [LANE_DATA_W-1:0] lane_word_t;

endpackage

// File: rtl/striping_lane_fifo.sv
// Per-lane FIFO with occupancy counter and head register that holds the last popped word while empty.
module striping_lane_fifo #(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk_2f,
   input  logic              reset_L,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wr_data,
   output logic              full,
   output logic              empty,
   output logic [DATA_W-1:0] head_data
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count;
   logic [DATA_W-1:0] last_pop;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == (AW+1)'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // While empty the lane shows the word most recently handed downstream.
   assign head_data = empty ? last_pop : mem[rd_ptr];

   always_ff @(posedge clk_2f) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk_2f or negedge reset_L) begin
      if (!reset_L) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         last_pop <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop) begin
            rd_ptr   <= rd_ptr + AW'(1);
            last_pop <= mem[rd_ptr];
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/byte_striping_2lane.sv
// Alternates an input word stream across two lane FIFOs (lane 0 first).
// Build option IDLE_FILL_EN: empty lanes present IDLE_WORD instead of stale head data.
module byte_striping_2lane
   import byte_striping_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk_2f,
   input  logic              reset_L,
   input  logic [DATA_W-1:0] data_in,
   input  logic              valid_in,
   output logic              ready_out,
   output logic [DATA_W-1:0] lane_0,
   output logic              valid_0,
   input  logic              ready_0,
   output logic [DATA_W-1:0] lane_1,
   output logic              valid_1,
   input  logic              ready_1,
   output logic              active_lane
);

   logic              sel;
   logic              accept;
   logic [LANES-1:0]  full;
   logic [LANES-1:0]  empty;
   logic [LANES-1:0]  push;
   logic [LANES-1:0]  pop;
   logic [DATA_W-1:0] head_0;
   logic [DATA_W-1:0] head_1;

   // Depends only on FIFO state, never on valid_in or the lane readies.
   assign ready_out   = reset_L && !full[sel];
   assign accept      = valid_in && ready_out;
   assign push        = {accept && sel, accept && !sel};
   assign valid_0     = !empty[0];
   assign valid_1     = !empty[1];
   assign pop         = {valid_1 && ready_1, valid_0 && ready_0};
   assign active_lane = sel;

   always_ff @(posedge clk_2f or negedge reset_L) begin
      if (!reset_L)    sel <= 1'b0;
      else if (accept) sel <= ~sel;
   end

   striping_lane_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo_0 (
      .clk_2f    (clk_2f),
      .reset_L   (reset_L),
      .push      (push[0]),
      .pop       (pop[0]),
      .wr_data   (data_in),
      .full      (full[0]),
      .empty     (empty[0]),
      .head_data (head_0)
   );

   striping_lane_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo_1 (
      .clk_2f    (clk_2f),
      .reset_L   (reset_L),
      .push      (push[1]),
      .pop       (pop[1]),
      .wr_data   (data_in),
      .full      (full[1]),
      .empty     (empty[1]),
      .head_data (head_1)
   );

`ifdef IDLE_FILL_EN
   assign lane_0 = valid_0 ? head_0 : DATA_W'(IDLE_WORD);
   assign lane_1 = valid_1 ? head_1 : DATA_W'(IDLE_WORD);
`else
   assign lane_0 = head_0;
   assign lane_1 = head_1;
`endif

endmodule

// File: tb/tb_byte_striping_2lane.sv
// Scoreboard bench for byte_striping_2lane: accepted words are queued per lane by arrival parity,
// a negedge monitor checks handshake, lane data, idle value and hold stability.
module tb_byte_striping_2lane;

   localparam int DEPTH = 2;

   logic        clk_2f   = 1'b0;
   logic        reset_L  = 1'b0;
   logic [31:0] data_in  = '0;
   logic        valid_in = 1'b0;
   logic        ready_0  = 1'b0;
   logic        ready_1  = 1'b0;
   logic        ready_out;
   logic [31:0] lane_0;
   logic [31:0] lane_1;
   logic        valid_0;
   logic        valid_1;
   logic        active_lane;

   byte_striping_2lane #(.DATA_W(32), .FIFO_DEPTH(DEPTH)) dut (
      .clk_2f      (clk_2f),
      .reset_L     (reset_L),
      .data_in     (data_in),
      .valid_in    (valid_in),
      .ready_out   (ready_out),
      .lane_0      (lane_0),
      .valid_0     (valid_0),
      .ready_0     (ready_0),
      .lane_1      (lane_1),
      .valid_1     (valid_1),
      .ready_1     (ready_1),
      .active_lane (active_lane)
   );

   always #5 clk_2f = ~clk_2f;

   logic [31:0] q0[$];
   logic [31:0] q1[$];
   bit          lane_m = 1'b0;
   int          checks = 0;
   int          passed = 0;
   int          rel_in = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [31:0] idle_word(input logic [31:0] last);
`ifdef IDLE_FILL_EN
      return 32'hBCBCBCBC;
`else
      return last;
`endif
   endfunction

   // One clock: note whether the edge accepts, then record the word in the lane it must reach.
   task automatic step(output bit acc);
      @(negedge clk_2f);
      acc = valid_in && ready_out && reset_L;
      @(posedge clk_2f);
      #1;
      if (acc) begin
         if (lane_m == 1'b0) q0.push_back(data_in);
         else                q1.push_back(data_in);
         lane_m = ~lane_m;
      end
      if (rel_in > 0) begin
         rel_in--;
         if (rel_in == 0) ready_1 = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      bit acc;
      valid_in = 1'b0;
      repeat (n) step(acc);
   endtask

   task automatic drive_word(input logic [31:0] d);
      bit acc;
      int n;
      n        = 0;
      valid_in = 1'b1;
      data_in  = d;
      do begin
         step(acc);
         n++;
      end while (!acc && n < 40);
      if (!acc) begin
         checks++;
         $display("FAIL drive_word timeout: word %h not accepted in %0d cycles", d, n);
      end
      valid_in = 1'b0;
   endtask

   task automatic do_reset();
      reset_L  = 1'b0;
      valid_in = 1'b0;
      q0.delete();
      q1.delete();
      lane_m = 1'b0;
      #1;
      check("rst_ready_out", {31'd0, ready_out}, 32'd0);
      check("rst_valid_0", {31'd0, valid_0}, 32'd0);
      check("rst_valid_1", {31'd0, valid_1}, 32'd0);
      idle(2);
      reset_L = 1'b1;
   endtask

   task automatic align_lane0();
      if (lane_m) drive_word($urandom);
   endtask

   // Monitor: expectations come from the queues before this cycle's pops are applied.
   logic [31:0] last0 = '0, last1 = '0, prev0 = '0, prev1 = '0;
   bit          hold0 = 1'b0, hold1 = 1'b0;

   initial begin
      forever begin
         @(negedge clk_2f);
         if (!reset_L) begin
            last0 = '0;
            last1 = '0;
            hold0 = 1'b0;
            hold1 = 1'b0;
            check("reset_ready_out", {31'd0, ready_out}, 32'd0);
            check("reset_valid_0", {31'd0, valid_0}, 32'd0);
            check("reset_valid_1", {31'd0, valid_1}, 32'd0);
            check("reset_lane_0", lane_0, idle_word(32'd0));
            check("reset_lane_1", lane_1, idle_word(32'd0));
         end else begin
            check("ready_out", {31'd0, ready_out},
                  {31'd0, ((lane_m ? q1.size() : q0.size()) < DEPTH)});
            check("active_lane", {31'd0, active_lane}, {31'd0, lane_m});
            check("valid_0", {31'd0, valid_0}, {31'd0, (q0.size() > 0)});
            check("valid_1", {31'd0, valid_1}, {31'd0, (q1.size() > 0)});
            if (q0.size() > 0) check("lane_0_head", lane_0, q0[0]);
            else               check("lane_0_idle", lane_0, idle_word(last0));
            if (q1.size() > 0) check("lane_1_head", lane_1, q1[0]);
            else               check("lane_1_idle", lane_1, idle_word(last1));
            if (hold0) check("lane_0_stable", lane_0, prev0);
            if (hold1) check("lane_1_stable", lane_1, prev1);
            hold0 = valid_0 && !ready_0;
            hold1 = valid_1 && !ready_1;
            prev0 = lane_0;
            prev1 = lane_1;
            if (valid_0 && ready_0 && q0.size() > 0) last0 = q0.pop_front();
            if (valid_1 && ready_1 && q1.size() > 0) last1 = q1.pop_front();
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      bit pat [6];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

      do_reset();

      // Basic alternation with both consumers ready.
      ready_0 = 1'b1;
      ready_1 = 1'b1;
      drive_word(32'h11111111);
      drive_word(32'h22222222);
      drive_word(32'h33333333);
      drive_word(32'h44444444);
      idle(3);

      // Lane 1 stalled: FIFO1 fills, source back-pressured, then released.
      ready_1 = 1'b0;
      rel_in  = 12;
      for (int i = 0; i < 6; i++) drive_word(32'hA0000000 + i);
      idle(6);

      // Idle gaps must not skip a lane.
      for (int i = 0; i < 6; i++) begin
         if (pat[i]) drive_word($urandom);
         else        idle(1);
      end
      idle(3);

      // Simultaneous push and pop on FIFO0 holding one entry.
      align_lane0();
      idle(2);
      ready_0 = 1'b0;
      drive_word(32'hC0C0C0C0);
      drive_word(32'hC1C1C1C1);
      ready_0 = 1'b1;
      drive_word(32'hC2C2C2C2);
      check("pushpop_valid_0", {31'd0, valid_0}, 32'd1);
      check("pushpop_head", lane_0, 32'hC2C2C2C2);
      idle(3);

      // Reset mid-stream with both FIFOs occupied.
      ready_0 = 1'b0;
      ready_1 = 1'b0;
      drive_word(32'hD0D0D0D0);
      drive_word(32'hD1D1D1D1);
      drive_word(32'hD2D2D2D2);
      do_reset();
      check("post_reset_lane", {31'd0, active_lane}, 32'd0);
      drive_word(32'hE0E0E0E0);
      check("post_reset_valid_0", {31'd0, valid_0}, 32'd1);
      check("post_reset_lane_0", lane_0, 32'hE0E0E0E0);
      ready_0 = 1'b1;
      ready_1 = 1'b1;
      idle(4);

      // Random traffic with held-until-accepted source.
      acc = 1'b1;
      for (int i = 0; i < 500; i++) begin
         if (acc || !valid_in) begin
            valid_in = ($urandom % 4) != 0;
            data_in  = $urandom;
         end
         ready_0 = ($urandom % 3) != 0;
         ready_1 = ($urandom % 3) != 0;
         if (i == 250) begin
            do_reset();
            acc = 1'b1;
         end else begin
            step(acc);
         end
      end

      valid_in = 1'b0;
      ready_0  = 1'b1;
      ready_1  = 1'b1;
      idle(8);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
